// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipe: stalls, flushes, EX forwarding, dmem wait FSM.
// Optional HAZ_PERF_CNT_EN adds saturating memStallCnt/lwStallCnt outputs.
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [4:0] rs1d,
    input  logic [4:0] rs2d,
    input  logic [4:0] rs1e,
    input  logic [4:0] rs2e,
    input  logic [4:0] rde,
    input  logic [1:0] rsltSrce,
    input  logic       pcSrce,
    input  logic [4:0] rdm,
    input  logic       regWrtm,
    input  logic       memReqm,
    input  logic [4:0] rdw,
    input  logic       regWrtw,
    input  logic       dmemRdy,
    output logic       stallf,
    output logic       stalld,
    output logic       stalle,
    output logic       stallm,
    output logic       stallw,
    output logic       flushd,
    output logic       flushe,
    output logic [1:0] fwdAe,
    output logic [1:0] fwdBe,
    output logic       dmemReq,
    output logic       memErr
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0] memStallCnt,
    output logic [31:0] lwStallCnt
`endif
);

    typedef enum logic {
        MEM_IDLE,
        MEM_WAIT
    } memState_t;

    localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(MEM_TIMEOUT);

    memState_t        state, stateNext;
    logic [CNT_W-1:0] waitCnt, waitCntNext;
    logic             memErrSet;
    logic             memStall;
    logic             dmemReqRaw;
    logic             lwStall;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= MEM_IDLE;
            waitCnt <= '0;
            memErr  <= 1'b0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
            memErr  <= memErr | memErrSet;
        end
    end

    // Timeout releases the pipe exactly as a completed access would.
    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        memErrSet   = 1'b0;
        memStall    = 1'b0;
        dmemReqRaw  = 1'b0;
        case (state)
            MEM_IDLE: begin
                dmemReqRaw = memReqm;
                if (memReqm && !dmemRdy) begin
                    memStall    = 1'b1;
                    stateNext   = MEM_WAIT;
                    waitCntNext = CNT_W'(1);
                end
            end
            MEM_WAIT: begin
                dmemReqRaw = 1'b1;
                if (dmemRdy) begin
                    stateNext   = MEM_IDLE;
                    waitCntNext = '0;
                end else if (waitCnt == TIMEOUT) begin
                    stateNext   = MEM_IDLE;
                    waitCntNext = '0;
                    memErrSet   = 1'b1;
                end else begin
                    memStall    = 1'b1;
                    waitCntNext = waitCnt + CNT_W'(1);
                end
            end
            default: begin
                stateNext   = MEM_IDLE;
                waitCntNext = '0;
            end
        endcase
    end

    assign lwStall = (rsltSrce == 2'b01) && (rde != 5'd0) && ((rde == rs1d) || (rde == rs2d));

    // A memory stall freezes every stage, so branch/load-use decisions wait for release.
    always_comb begin
        stallf  = 1'b0;
        stalld  = 1'b0;
        stalle  = 1'b0;
        stallm  = 1'b0;
        stallw  = 1'b0;
        flushd  = 1'b1;
        flushe  = 1'b1;
        dmemReq = 1'b0;
        if (rstn) begin
            dmemReq = dmemReqRaw;
            if (memStall) begin
                stallf = 1'b1;
                stalld = 1'b1;
                stalle = 1'b1;
                stallm = 1'b1;
                stallw = 1'b1;
                flushd = 1'b0;
                flushe = 1'b0;
            end else begin
                stallf = lwStall;
                stalld = lwStall;
                flushd = pcSrce;
                flushe = lwStall | pcSrce;
            end
        end
    end

    always_comb begin
        fwdAe = 2'b00;
        if (rstn) begin
            if (regWrtm && (rdm != 5'd0) && (rdm == rs1e)) begin
                fwdAe = 2'b10;
            end else if (regWrtw && (rdw != 5'd0) && (rdw == rs1e)) begin
                fwdAe = 2'b01;
            end
        end
    end

    always_comb begin
        fwdBe = 2'b00;
        if (rstn) begin
            if (regWrtm && (rdm != 5'd0) && (rdm == rs2e)) begin
                fwdBe = 2'b10;
            end else if (regWrtw && (rdw != 5'd0) && (rdw == rs2e)) begin
                fwdBe = 2'b01;
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            memStallCnt <= '0;
            lwStallCnt  <= '0;
        end else begin
            if (memStall && (memStallCnt != '1)) begin
                memStallCnt <= memStallCnt + 32'd1;
            end
            if (lwStall && (lwStallCnt != '1)) begin
                lwStallCnt <= lwStallCnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, hand sequences, random vs. reference model.
module tb_pipe_hazard_ctrl;

    localparam int unsigned TMO = 6;

    logic       clk = 1'b0;
    logic       rstn;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic [1:0] rsltSrce;
    logic       pcSrce, regWrtm, memReqm, regWrtw, dmemRdy;
    logic       stallf, stalld, stalle, stallm, stallw, flushd, flushe;
    logic [1:0] fwdAe, fwdBe;
    logic       dmemReq, memErr;
    logic [7:0] ctl;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] memStallCnt, lwStallCnt;
`endif

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(8)) dut (
        .clk(clk), .rstn(rstn),
        .rs1d(rs1d), .rs2d(rs2d), .rs1e(rs1e), .rs2e(rs2e), .rde(rde),
        .rsltSrce(rsltSrce), .pcSrce(pcSrce),
        .rdm(rdm), .regWrtm(regWrtm), .memReqm(memReqm),
        .rdw(rdw), .regWrtw(regWrtw), .dmemRdy(dmemRdy),
        .stallf(stallf), .stalld(stalld), .stalle(stalle), .stallm(stallm), .stallw(stallw),
        .flushd(flushd), .flushe(flushe), .fwdAe(fwdAe), .fwdBe(fwdBe),
        .dmemReq(dmemReq), .memErr(memErr)
`ifdef HAZ_PERF_CNT_EN
        , .memStallCnt(memStallCnt), .lwStallCnt(lwStallCnt)
`endif
    );

    // {stallf,stalld,stalle,stallm,stallw,flushd,flushe,dmemReq}
    assign ctl = {stallf, stalld, stalle, stallm, stallw, flushd, flushe, dmemReq};

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks how many cycles the current access has already waited.
    int          mWaited = 0;
    bit          mErr = 1'b0;
    longint      mMemCnt = 0;
    longint      mLwCnt = 0;

    function automatic logic [1:0] fwdSel(input logic [4:0] rs);
        if (regWrtm && rdm != 0 && rdm == rs) return 2'b10;
        if (regWrtw && rdw != 0 && rdw == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit mInProg();
        return memReqm || (mWaited > 0);
    endfunction

    function automatic bit mMemStall();
        return rstn && mInProg() && !dmemRdy && (mWaited < int'(TMO));
    endfunction

    function automatic bit mLw();
        return rstn && rsltSrce == 2'b01 && rde != 0 && (rde == rs1d || rde == rs2d);
    endfunction

    function automatic logic [7:0] mCtl();
        bit lw;
        if (!rstn) return 8'b00000110;
        lw = mLw();
        if (mMemStall()) return 8'b11111001;
        return {lw, lw, 3'b000, pcSrce, lw | pcSrce, mInProg()};
    endfunction

    task automatic modelAdvance();
        if (!rstn) begin
            mWaited = 0;
            mErr    = 1'b0;
            mMemCnt = 0;
            mLwCnt  = 0;
        end else begin
            if (mMemStall() && mMemCnt < 64'hFFFFFFFF) mMemCnt++;
            if (mLw() && mLwCnt < 64'hFFFFFFFF) mLwCnt++;
            if (mInProg() && !dmemRdy) begin
                if (mWaited < int'(TMO)) mWaited++;
                else begin
                    mErr    = 1'b1;
                    mWaited = 0;
                end
            end else begin
                mWaited = 0;
            end
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        modelAdvance();
        @(negedge clk);
    endtask

    task automatic clearInputs();
        rs1d = 0; rs2d = 0; rs1e = 0; rs2e = 0; rde = 0; rdm = 0; rdw = 0;
        rsltSrce = 0; pcSrce = 0; regWrtm = 0; memReqm = 0; regWrtw = 0; dmemRdy = 0;
    endtask

    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
        logic [1:0] rsltSrce;
        logic       pcSrce;
        logic [4:0] rdm;
        logic       regWrtm;
        logic [4:0] rdw;
        logic       regWrtw;
        logic [7:0] expCtl;
        logic [1:0] expA, expB;
    } vec_t;

    vec_t vecs[12];

    initial begin
        //            rs1d rs2d rs1e rs2e rde src pc rdm wm rdw ww  expCtl        A      B
        vecs[0]  = '{3,  5,   0,   0,   5,  1,  0, 0,  0, 0,  0, 8'b11000010, 2'b00, 2'b00};
        vecs[1]  = '{0,  0,   0,   0,   0,  1,  0, 0,  0, 0,  0, 8'b00000000, 2'b00, 2'b00};
        vecs[2]  = '{9,  1,   0,   0,   9,  1,  0, 0,  0, 0,  0, 8'b11000010, 2'b00, 2'b00};
        vecs[3]  = '{3,  5,   0,   0,   5,  0,  0, 0,  0, 0,  0, 8'b00000000, 2'b00, 2'b00};
        vecs[4]  = '{1,  2,   0,   0,   4,  1,  1, 0,  0, 0,  0, 8'b00000110, 2'b00, 2'b00};
        vecs[5]  = '{4,  2,   0,   0,   4,  1,  1, 0,  0, 0,  0, 8'b11000110, 2'b00, 2'b00};
        vecs[6]  = '{0,  0,   7,   0,   0,  0,  0, 7,  1, 7,  1, 8'b00000000, 2'b10, 2'b00};
        vecs[7]  = '{0,  0,   7,   0,   0,  0,  0, 7,  0, 7,  1, 8'b00000000, 2'b01, 2'b00};
        vecs[8]  = '{0,  0,   0,   0,   0,  0,  0, 0,  1, 0,  1, 8'b00000000, 2'b00, 2'b00};
        vecs[9]  = '{0,  0,   3,   12,  0,  0,  0, 12, 0, 12, 1, 8'b00000000, 2'b00, 2'b01};
        vecs[10] = '{0,  0,   3,   3,   0,  0,  0, 3,  1, 3,  1, 8'b00000000, 2'b10, 2'b10};
        vecs[11] = '{0,  0,   6,   6,   0,  0,  0, 6,  1, 2,  1, 8'b00000000, 2'b10, 2'b10};

        // Reset state, with inputs that would otherwise stall, flush and forward.
        clearInputs();
        rstn = 1'b0;
        memReqm = 1; rsltSrce = 1; rde = 5; rs1d = 5; regWrtm = 1; rdm = 4; rs1e = 4;
        #2;
        check("reset ctl", 32'(ctl), 32'(8'b00000110));
        check("reset fwdA", 32'(fwdAe), 0);
        check("reset memErr", 32'(memErr), 0);
        nextCycle();
        clearInputs();
        rstn = 1'b1;

        for (int i = 0; i < 12; i++) begin
            rs1d = vecs[i].rs1d; rs2d = vecs[i].rs2d; rs1e = vecs[i].rs1e; rs2e = vecs[i].rs2e;
            rde = vecs[i].rde; rsltSrce = vecs[i].rsltSrce; pcSrce = vecs[i].pcSrce;
            rdm = vecs[i].rdm; regWrtm = vecs[i].regWrtm; rdw = vecs[i].rdw; regWrtw = vecs[i].regWrtw;
            #1;
            check($sformatf("vec%0d ctl", i), 32'(ctl), 32'(vecs[i].expCtl));
            check($sformatf("vec%0d fwdA", i), 32'(fwdAe), 32'(vecs[i].expA));
            check($sformatf("vec%0d fwdB", i), 32'(fwdBe), 32'(vecs[i].expB));
            nextCycle();
        end
        clearInputs();

        // Three wait cycles then ready.
        memReqm = 1;
        for (int i = 0; i < 4; i++) begin
            dmemRdy = (i == 3);
            #1;
            check($sformatf("memwait c%0d", i), 32'(ctl), (i < 3) ? 32'(8'b11111001) : 32'(8'b00000001));
            nextCycle();
        end
        memReqm = 0; dmemRdy = 0;
        #1;
        check("memwait after ctl", 32'(ctl), 0);
        check("memwait memErr", 32'(memErr), 0);
        nextCycle();

        // Branch resolved while frozen: flushes held off until release.
        memReqm = 1; pcSrce = 1;
        for (int i = 0; i < 3; i++) begin
            dmemRdy = (i == 2);
            #1;
            check($sformatf("branch c%0d", i), 32'(ctl), (i < 2) ? 32'(8'b11111001) : 32'(8'b00000111));
            nextCycle();
        end
        clearInputs();
        #1;
        check("branch after ctl", 32'(ctl), 0);
        nextCycle();

        // Reset in the middle of a wait (waitCnt reaches 5).
        memReqm = 1;
        repeat (5) begin
            #1;
            check("midwait stall", 32'(ctl), 32'(8'b11111001));
            nextCycle();
        end
        #2 rstn = 1'b0;
        #1;
        check("midwait reset ctl", 32'(ctl), 32'(8'b00000110));
        check("midwait reset memErr", 32'(memErr), 0);
        nextCycle();
        rstn = 1'b1; memReqm = 0;
        #1;
        check("post reset idle ctl", 32'(ctl), 0);
        nextCycle();
        memReqm = 1; dmemRdy = 1;
        #1;
        check("zero-wait ctl", 32'(ctl), 32'(8'b00000001));
        nextCycle();
        memReqm = 0; dmemRdy = 0;
        #1;
        check("post midwait memErr", 32'(memErr), 0);
        nextCycle();

        // Timeout: TMO stall cycles, forced release, sticky memErr.
        memReqm = 1;
        for (int i = 0; i <= int'(TMO); i++) begin
            #1;
            check($sformatf("timeout c%0d", i), 32'(ctl), (i < int'(TMO)) ? 32'(8'b11111001) : 32'(8'b00000001));
            check($sformatf("timeout err c%0d", i), 32'(memErr), 0);
            nextCycle();
        end
        memReqm = 0;
        for (int i = 0; i < 4; i++) begin
            memReqm = (i == 1);
            dmemRdy = (i == 1);
            #1;
            check($sformatf("sticky memErr %0d", i), 32'(memErr), 1);
            nextCycle();
        end
        clearInputs();
        rstn = 1'b0;
        #1;
        check("memErr cleared", 32'(memErr), 0);
        nextCycle();
        rstn = 1'b1;

        // Randomized run against the model.
        for (int n = 0; n < 3000; n++) begin
            rstn = ($urandom_range(0, 99) != 0);
            rs1d = 5'($urandom_range(0, 3)); rs2d = 5'($urandom_range(0, 3));
            rs1e = 5'($urandom_range(0, 3)); rs2e = 5'($urandom_range(0, 3));
            rde  = 5'($urandom_range(0, 3)); rdm  = 5'($urandom_range(0, 3));
            rdw  = 5'($urandom_range(0, 3));
            rsltSrce = 2'($urandom_range(0, 3));
            pcSrce   = ($urandom_range(0, 3) == 0);
            regWrtm  = 1'($urandom_range(0, 1));
            regWrtw  = 1'($urandom_range(0, 1));
            memReqm  = 1'($urandom_range(0, 1));
            dmemRdy  = ($urandom_range(0, 3) == 0);
            #1;
            check("rand ctl", 32'(ctl), 32'(mCtl()));
            check("rand fwdA", 32'(fwdAe), rstn ? 32'(fwdSel(rs1e)) : 0);
            check("rand fwdB", 32'(fwdBe), rstn ? 32'(fwdSel(rs2e)) : 0);
            check("rand memErr", 32'(memErr), rstn ? 32'(mErr) : 0);
`ifdef HAZ_PERF_CNT_EN
            check("rand memStallCnt", memStallCnt, rstn ? 32'(mMemCnt) : 0);
            check("rand lwStallCnt", lwStallCnt, rstn ? 32'(mLwCnt) : 0);
`endif
            nextCycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
